digdug_devbus_arbiter: RTL and testbench
========================================

Name: digdug_devbus_arbiter

Overview:
- Shares the common I/O device bus (DEV_AD/RD/WR/DI/DV/DO) among the three CPUs: main, sub and sound.
- Each CPU presents a request; the arbiter grants one at a time round-robin and runs a single bus cycle on the device bus.
- For reads it waits for DEV_DV, with a timeout; it then returns data and a one-cycle ACK.
- Sits between the CPU cores and the I/O device module; runs entirely on MCLK.

Parameters:
- TMO, 15: maximum WAITDV cycles before a read is forced complete.
- TMO_DATA, 8'hFF: read data returned on timeout.

Ports:
- MCLK  in  1  master clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  3  per-CPU request; bit0 = main, bit1 = sub, bit2 = sound. Held until ACK.
- RQ_AD  in  48  per-CPU address; [16i+15:16i] belongs to CPU i.
- RQ_WR  in  3  per-CPU direction; 1 = write, 0 = read.
- RQ_WD  in  24  per-CPU write data; [8i+7:8i] belongs to CPU i.
- ACK  out  3  one-hot, one-cycle completion strobe.
- RQ_RD  out  8  read data; valid in the ACK cycle and held until the next read completes.
- DEV_AD  out  16  device address.
- DEV_RD  out  1  read strobe.
- DEV_WR  out  1  write strobe.
- DEV_DI  out  8  write data to the device.
- DEV_DV  in  1  device read-data valid.
- DEV_DO  in  8  device read data.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- GNT  out  2  index of the current or last granted CPU (0..2), for debug.

Behaviour:
Clocking and reset
- Single clock MCLK. Reset is synchronous and active-high.
- RESET forces: state = IDLE, ACK = 0, DEV_RD = 0, DEV_WR = 0, DEV_AD = 0, DEV_DI = 0, RQ_RD = 0, BUSY = 0, GNT = 2, last-grant pointer LAST = 2 (so CPU0 wins first), timeout counter = 0.
- RESET mid-transaction aborts it with no ACK. Any strobe in flight drops at that edge.

State machine (all outputs registered)
- IDLE: if REQ != 0, select the winner by searching LAST+1, LAST+2, LAST+3, all mod 3.
  - Latch the winner's address, direction and data into DEV_AD/DEV_DI and internal regs.
  - GNT <= winner; go to ISSUE.
  - REQ is sampled only in IDLE.
- ISSUE (exactly 1 cycle): DEV_WR = 1 if write, else DEV_RD = 1. DEV_AD/DEV_DI are stable.
  - Write: go to DONE.
  - Read: clear the counter and go to WAITDV.
- WAITDV: DEV_RD deasserted. DEV_DV is sampled only here.
  - DEV_DV = 1: RQ_RD <= DEV_DO; go to DONE.
  - Else, if counter == TMO: RQ_RD <= TMO_DATA; go to DONE.
  - Else: counter++.
- DONE (1 cycle): ACK[GNT] = 1; LAST <= GNT; go to IDLE.

Timing and latency
- DEV_AD/DEV_DI are held from ISSUE through DONE.
- Minimum back-to-back spacing between ISSUE cycles is 3 cycles.
- Let k be the edge at which REQ is first sampled in IDLE:
  - write: DEV_WR high in cycle k+1, ACK in cycle k+2;
  - read with DV in the first WAITDV cycle: ACK in cycle k+3;
  - read that times out: ACK in cycle k+3+TMO.

Boundary conditions
- Simultaneous requests are strictly round-robin: no CPU is granted twice while another is waiting.
- A requester that drops REQ mid-transaction still completes and still receives its ACK.
- A requester that keeps REQ high in the cycle after ACK is treated as a new request.
- DEV_DV outside WAITDV is ignored.
- Counter width is clog2(TMO+1); the counter never wraps.

Optional Feature:
- Macro: DEVARB_FIXED_PRIO_EN.
- Defined: fixed priority in IDLE (CPU0 > CPU1 > CPU2); LAST is unused.
- Undefined: round-robin as specified above.
- The rest of the FSM is identical in both modes.

Test Plan:
- Reset, then CPU0 write: RQ_AD = 16'h6800, RQ_WD = 8'h5A. Expect DEV_WR one cycle with DEV_AD = 6800, DEV_DI = 5A; ACK = 3'b001 at k+2; BUSY low afterwards.
- CPU1 read of 16'h7000, DEV_DV returned 2 cycles after DEV_RD with DEV_DO = 8'hC3. Expect ACK = 3'b010 and RQ_RD = C3 in the ACK cycle, 5 cycles after k.
- CPU2 read, DEV_DV never asserted, TMO = 15. Expect ACK = 3'b100 at k+18 and RQ_RD = FF.
- REQ = 3'b111 held continuously after reset. Expect grant order 0,1,2,0,1,2 on GNT/ACK. With DEVARB_FIXED_PRIO_EN, expect 0 repeatedly while REQ[0] stays high.
- RESET asserted during WAITDV. Expect no ACK, all outputs at reset values next cycle, and the next grant going to CPU0.
- DEV_DV pulse during ISSUE followed by a real DV in WAITDV with DEV_DO = 8'h11. Expect RQ_RD = 11 (the early pulse ignored).

Source files
------------

// File: rtl/digdug_devbus_arbiter.sv
// digdug_devbus_arbiter: shares the I/O device bus among the main, sub and
// sound CPUs. One request is granted at a time and runs a single device bus
// cycle. Reads wait for DEV_DV, with a timeout. Each grant ends with a
// one-cycle ACK.
// Optional build macro DEVARB_FIXED_PRIO_EN: fixed priority CPU0 > CPU1 > CPU2
// replaces round-robin selection.
module digdug_devbus_arbiter #(
  parameter int unsigned TMO      = 15,
  parameter logic [7:0]  TMO_DATA = 8'hFF
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic [2:0]  REQ,
  input  logic [47:0] RQ_AD,
  input  logic [2:0]  RQ_WR,
  input  logic [23:0] RQ_WD,
  output logic [2:0]  ACK,
  output logic [7:0]  RQ_RD,
  output logic [15:0] DEV_AD,
  output logic        DEV_RD,
  output logic        DEV_WR,
  output logic [7:0]  DEV_DI,
  input  logic        DEV_DV,
  input  logic [7:0]  DEV_DO,
  output logic        BUSY,
  output logic [1:0]  GNT
);

  localparam int unsigned    CW    = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0]  TMO_C = CW'(TMO);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAITDV,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [1:0]      r_gnt;
  logic            r_wr;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_ack;
  logic [7:0]      r_rd;
  logic [15:0]     r_dev_ad;
  logic [7:0]      r_dev_di;
  logic            r_dev_rd;
  logic            r_dev_wr;
  logic            r_busy;
  logic [1:0]      w_win;
  logic            w_hit;
`ifndef DEVARB_FIXED_PRIO_EN
  logic [1:0]      r_last;
  logic [1:0]      w_idx;
`endif

  assign ACK    = r_ack;
  assign RQ_RD  = r_rd;
  assign DEV_AD = r_dev_ad;
  assign DEV_DI = r_dev_di;
  assign DEV_RD = r_dev_rd;
  assign DEV_WR = r_dev_wr;
  assign BUSY   = r_busy;
  assign GNT    = r_gnt;

  // Winner selection among the current requesters
  always_comb begin
    w_win = 2'd0;
    w_hit = 1'b0;
`ifdef DEVARB_FIXED_PRIO_EN
    for (int unsigned i = 0; i < 3; i++) begin
      if (!w_hit && REQ[i]) begin
        w_hit = 1'b1;
        w_win = 2'(i);
      end
    end
`else
    w_idx = 2'd0;
    for (int unsigned off = 1; off <= 3; off++) begin
      w_idx = 2'((32'(r_last) + off) % 3);
      if (!w_hit && REQ[w_idx]) begin
        w_hit = 1'b1;
        w_win = w_idx;
      end
    end
`endif
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_hit) w_nxt = S_ISSUE;
      S_ISSUE:  w_nxt = r_wr ? S_DONE : S_WAITDV;
      S_WAITDV: if (DEV_DV || (r_cnt == TMO_C)) w_nxt = S_DONE;
      S_DONE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge MCLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  // Registered datapath and outputs; strobes and ACK are registered from the
  // state being left, so each appears in the cycle after its state is entered
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_gnt    <= 2'd2;
      r_wr     <= 1'b0;
      r_cnt    <= '0;
      r_ack    <= '0;
      r_rd     <= '0;
      r_dev_ad <= '0;
      r_dev_di <= '0;
      r_dev_rd <= 1'b0;
      r_dev_wr <= 1'b0;
      r_busy   <= 1'b0;
`ifndef DEVARB_FIXED_PRIO_EN
      r_last   <= 2'd2;
`endif
    end else begin
      r_ack    <= '0;
      r_dev_rd <= 1'b0;
      r_dev_wr <= 1'b0;
      r_busy   <= (w_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_gnt    <= w_win;
            r_wr     <= RQ_WR[w_win];
            r_dev_ad <= RQ_AD[{w_win, 4'b0000} +: 16];
            r_dev_di <= RQ_WD[{w_win, 3'b000} +: 8];
          end
        end
        S_ISSUE: begin
          if (r_wr) begin
            r_dev_wr <= 1'b1;
          end else begin
            r_dev_rd <= 1'b1;
            r_cnt    <= '0;
          end
        end
        S_WAITDV: begin
          if (DEV_DV)              r_rd  <= DEV_DO;
          else if (r_cnt == TMO_C) r_rd  <= TMO_DATA;
          else                     r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_ack  <= 3'b001 << r_gnt;
`ifndef DEVARB_FIXED_PRIO_EN
          r_last <= r_gnt;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digdug_devbus_arbiter.sv
// Bench for digdug_devbus_arbiter: transaction-level reference model with a
// scoreboard queue; a separate monitor checks strobes, BUSY, ACK, GNT, RQ_RD.
module tb_digdug_devbus_arbiter;

  localparam int unsigned TMO   = 15;
  localparam int          NEVER = 1000;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic [2:0]  REQ = '0;
  logic [47:0] RQ_AD = '0;
  logic [2:0]  RQ_WR = '0;
  logic [23:0] RQ_WD = '0;
  logic [2:0]  ACK;
  logic [7:0]  RQ_RD;
  logic [15:0] DEV_AD;
  logic        DEV_RD;
  logic        DEV_WR;
  logic [7:0]  DEV_DI;
  logic        DEV_DV = 1'b0;
  logic [7:0]  DEV_DO = '0;
  logic        BUSY;
  logic [1:0]  GNT;

  digdug_devbus_arbiter #(.TMO(TMO), .TMO_DATA(8'hFF)) dut (
    .MCLK(MCLK), .RESET(RESET), .REQ(REQ), .RQ_AD(RQ_AD), .RQ_WR(RQ_WR),
    .RQ_WD(RQ_WD), .ACK(ACK), .RQ_RD(RQ_RD), .DEV_AD(DEV_AD),
    .DEV_RD(DEV_RD), .DEV_WR(DEV_WR), .DEV_DI(DEV_DI), .DEV_DV(DEV_DV),
    .DEV_DO(DEV_DO), .BUSY(BUSY), .GNT(GNT)
  );

  always #5 MCLK = ~MCLK;

  // cycle n = interval after rising edge n
  int cyc = 0;
  always @(posedge MCLK) cyc <= cyc + 1;

  typedef struct {
    int         k;
    int         ackc;
    int         cpu;
    logic       wr;
    logic [15:0] ad;
    logic [7:0] wd;
    logic [7:0] rd;
  } txn_t;

  txn_t sbq[$];
  int checks = 0;
  int passes = 0;

  // stimulus / model state
  logic [15:0] req_ad [3];
  logic        req_wr [3];
  logic [7:0]  req_wd [3];
  logic [2:0]  req_set = '0;
  logic [2:0]  hold_mask = '0;
  bit          random_mode = 0;
  bit          rst_next = 1;
  int          m_last = 2;
  int          m_free = 0;
  logic [7:0]  m_rd = '0;
  int          dv_cyc = -1;
  logic [7:0]  dv_dat = '0;
  int          noise_cyc = -1;
  int          force_d = -1;
  int          force_dat = -1;
  bit          force_noise = 0;
  int          g_cnt = 0;
  int          last_k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic new_payload(input int i);
    req_ad[i] = 16'($urandom);
    req_wr[i] = 1'($urandom % 2);
    req_wd[i] = 8'($urandom);
  endtask

  // One cycle of stimulus: everything driven at the falling edge, and the
  // model decides what the arbiter does at the following rising edge.
  task automatic step();
    int n, w, d;
    logic [7:0] dat;
    txn_t t;
    @(negedge MCLK);
    n = cyc;
    RESET = rst_next;
    for (int i = 0; i < 3; i++) begin
      if (ACK[i]) begin
        if (random_mode ? ($urandom % 4 == 0) : hold_mask[i]) begin
          if (random_mode) new_payload(i);
        end else begin
          REQ[i] = 1'b0;
        end
      end
      if (random_mode && !REQ[i] && ($urandom % 5 == 0)) begin
        REQ[i] = 1'b1;
        new_payload(i);
      end
    end
    REQ = REQ | req_set;
    req_set = '0;
    for (int i = 0; i < 3; i++) begin
      RQ_AD[16*i +: 16] = req_ad[i];
      RQ_WR[i]          = req_wr[i];
      RQ_WD[8*i +: 8]   = req_wd[i];
    end
    if (rst_next) begin
      sbq.delete();
      m_last = 2; m_free = 0; m_rd = '0;
      dv_cyc = -1; noise_cyc = -1;
    end else if (n + 1 >= m_free && REQ != 0) begin
      w = -1;
`ifdef DEVARB_FIXED_PRIO_EN
      for (int i = 0; i < 3; i++) if (w < 0 && REQ[i]) w = i;
`else
      for (int off = 1; off <= 3; off++)
        if (w < 0 && REQ[(m_last + off) % 3]) w = (m_last + off) % 3;
`endif
      t.cpu = w; t.k = n + 1;
      t.wr = req_wr[w]; t.ad = req_ad[w]; t.wd = req_wd[w];
      if (force_d != -1) begin d = force_d; force_d = -1; end
      else d = int'($urandom_range(TMO + 3, 0));
      if (force_dat != -1) begin dat = 8'(force_dat); force_dat = -1; end
      else dat = 8'($urandom);
      if (t.wr) begin
        t.ackc = t.k + 2; t.rd = m_rd; dv_cyc = -1;
      end else if (d <= int'(TMO)) begin
        t.ackc = t.k + 3 + d; t.rd = dat; dv_cyc = t.k + 1 + d; dv_dat = dat;
      end else begin
        t.ackc = t.k + 3 + int'(TMO); t.rd = 8'hFF; dv_cyc = -1;
      end
      if (force_noise) noise_cyc = t.k;
      else if ($urandom % 2 == 0) noise_cyc = t.k + ((t.wr && $urandom % 2 == 1) ? 1 : 0);
      else noise_cyc = -1;
      force_noise = 0;
      m_rd = t.rd; m_last = w; m_free = t.ackc + 1;
      sbq.push_back(t);
      g_cnt++; last_k = t.k;
    end
    DEV_DV = (n == dv_cyc) || (n == noise_cyc);
    DEV_DO = (n == dv_cyc) ? dv_dat : 8'($urandom);
  endtask

  task automatic run_until_idle(input int bound);
    int c;
    c = 0;
    while ((sbq.size() != 0 || REQ != 0 || req_set != 0) && c < bound) begin
      step();
      c++;
    end
    if (c >= bound) begin
      checks++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", bound);
    end
  endtask

  // Monitor: compares DUT outputs to the scoreboard front every cycle
  txn_t mt;
  always @(posedge MCLK) begin
    #1;
    if (sbq.size() != 0 && cyc == sbq[0].k + 1) begin
      chk("strobe", {30'b0, DEV_WR, DEV_RD}, sbq[0].wr ? 32'd2 : 32'd1);
      if (sbq[0].wr) chk("dev_di", DEV_DI, sbq[0].wd);
    end else begin
      chk("strobe_idle", {30'b0, DEV_WR, DEV_RD}, 32'd0);
    end
    if (sbq.size() != 0 && cyc >= sbq[0].k && cyc < sbq[0].ackc) begin
      chk("busy", BUSY, 1);
      chk("dev_ad", DEV_AD, sbq[0].ad);
    end else begin
      chk("busy_idle", BUSY, 0);
    end
    if (sbq.size() != 0 && cyc == sbq[0].ackc) begin
      mt = sbq.pop_front();
      chk("ack", ACK, 32'd1 << mt.cpu);
      chk("gnt", GNT, mt.cpu);
      chk("rq_rd", RQ_RD, mt.rd);
    end else begin
      chk("ack_quiet", ACK, 0);
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, guard;
    for (int i = 0; i < 3; i++) begin
      req_ad[i] = '0; req_wr[i] = 1'b0; req_wd[i] = '0;
    end
    rst_next = 1;
    repeat (3) step();
    @(posedge MCLK); #2;
    chk("rst_busy", BUSY, 0);
    chk("rst_gnt", GNT, 2);
    chk("rst_rqrd", RQ_RD, 0);
    rst_next = 0;

    // CPU0 write
    req_ad[0] = 16'h6800; req_wr[0] = 1'b1; req_wd[0] = 8'h5A; req_set = 3'b001;
    run_until_idle(50);

    // CPU1 read, DV two cycles after DEV_RD
    req_ad[1] = 16'h7000; req_wr[1] = 1'b0; force_d = 2; force_dat = 8'hC3; req_set = 3'b010;
    run_until_idle(50);

    // CPU2 read, no DV: timeout
    req_ad[2] = 16'h7100; req_wr[2] = 1'b0; force_d = NEVER; req_set = 3'b100;
    run_until_idle(60);

    // All three held continuously
    for (int i = 0; i < 3; i++) new_payload(i);
    base = g_cnt; guard = 0;
    hold_mask = 3'b111; req_set = 3'b111;
    while (g_cnt < base + 6 && guard < 200) begin step(); guard++; end
    hold_mask = 3'b000;
    run_until_idle(200);

    // Reset during WAITDV
    req_ad[1] = 16'h7200; req_wr[1] = 1'b0; force_d = NEVER; req_set = 3'b010;
    base = g_cnt; guard = 0;
    step();
    while ((g_cnt == base || cyc < last_k + 3) && guard < 50) begin step(); guard++; end
    new_payload(0); new_payload(2);
    req_set = 3'b101; rst_next = 1;
    step();
    @(posedge MCLK); #2;
    chk("mid_rst_ack", ACK, 0);
    chk("mid_rst_strb", {DEV_WR, DEV_RD}, 0);
    chk("mid_rst_ad", DEV_AD, 0);
    chk("mid_rst_di", DEV_DI, 0);
    chk("mid_rst_rqrd", RQ_RD, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_gnt", GNT, 2);
    rst_next = 0;
    run_until_idle(300);

    // Early DV pulse in ISSUE ignored, real DV in WAITDV
    req_ad[0] = 16'h6810; req_wr[0] = 1'b0; force_noise = 1;
    force_d = 1; force_dat = 8'h11; req_set = 3'b001;
    run_until_idle(50);

    // Randomized traffic
    random_mode = 1;
    repeat (3000) step();
    random_mode = 0;
    run_until_idle(400);

    repeat (2) @(posedge MCLK);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
